mem_system_dm: RTL and testbench

Direct-mapped, write-back, write-allocate cache controller that answers the processor-side memory request handshake (Rd/Wr/Addr/DataIn → DataOut/Done/Stall/CacheHit) used by the memory-system benches and the pipeline's memory stage. It owns the tag, valid, dirty and data arrays. Misses are serviced through a fixed-latency, banked main-memory port, one word per cycle. It is the responder end of the interface that the performance bench drives.

---
 rtl/mem_system_dm_if.sv | 23 ++
 rtl/mem_system_dm.sv | 202 ++++++++++++++++++++
 tb/tb_mem_system_dm.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_system_dm_if.sv
// Processor-side request/response bundle of the direct-mapped cache controller.
// The requester holds Rd/Wr/Addr/DataIn until Done; the cache answers with Done/CacheHit/DataOut.
interface mem_system_dm_if;
  logic        Rd;
  logic        Wr;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        Err;

  modport master (
    output Rd, Wr, Addr, DataIn,
    input  DataOut, Done, Stall, CacheHit, Err
  );

  modport slave (
    input  Rd, Wr, Addr, DataIn,
    output DataOut, Done, Stall, CacheHit, Err
  );
endinterface

// File: rtl/mem_system_dm.sv
// Direct-mapped, write-back, write-allocate cache: 256 lines of four 16-bit words.
// Misses write back the dirty victim (WB0-WB3) and refill over a fixed-latency memory port.
module mem_system_dm #(
  parameter int MEM_LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_system_dm_if.slave cpu,
  output logic [15:0]    mem_addr,
  output logic           mem_rd,
  output logic           mem_wr,
  output logic [15:0]    mem_data_out,
  input  logic [15:0]    mem_data_in
);

  typedef enum logic [2:0] {IDLE, DONE, WB0, WB1, WB2, WB3, FILL} state_t;

  state_t       state;
  logic [4:0]   tag_arr  [256];
  logic [15:0]  data_arr [256][4];
  logic [255:0] valid;
  logic [255:0] dirty;

  logic [4:0]   req_tag;
  logic [7:0]   req_idx;
  logic [1:0]   req_off;
  logic         req_wr;
  logic [15:0]  req_data;
  logic [2:0]   fill_cyc;

  logic [15:0]  data_out_q;
  logic         done_q, hit_q, err_q, stall_q;

  assign cpu.DataOut  = data_out_q;
  assign cpu.Done     = done_q;
  assign cpu.CacheHit = hit_q;
  assign cpu.Err      = err_q;
  assign cpu.Stall    = stall_q;

  logic [4:0] a_tag;
  logic [7:0] a_idx;
  logic [1:0] a_off;
  assign a_tag = cpu.Addr[15:11];
  assign a_idx = cpu.Addr[10:3];
  assign a_off = cpu.Addr[2:1];

  logic accepting, illegal, accept, lookup_hit;
  assign accepting  = (state == IDLE) || (state == DONE);
  assign illegal    = (cpu.Rd & cpu.Wr) | ((cpu.Rd | cpu.Wr) & cpu.Addr[0]);
  assign accept     = (cpu.Rd ^ cpu.Wr) & ~cpu.Addr[0];
  assign lookup_hit = valid[a_idx] && (tag_arr[a_idx] == a_tag);

  // Fill cycle j issues word j (j<4) and captures word j-MEM_LAT (j>=MEM_LAT).
  logic       capture, fill_last;
  logic [1:0] cap_word, issue_next;
  assign capture    = fill_cyc >= 3'(MEM_LAT);
  assign fill_last  = fill_cyc == 3'(MEM_LAT + 3);
  assign cap_word   = 2'(fill_cyc - 3'(MEM_LAT));
  assign issue_next = fill_cyc[1:0] + 2'd1;

  state_t     wb_next_state;
  logic [1:0] wb_next_word;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wb_next_state = FILL;
    wb_next_word  = 2'd0;
    case (state)
      WB0:     begin wb_next_state = WB1; wb_next_word = 2'd1; end
      WB1:     begin wb_next_state = WB2; wb_next_word = 2'd2; end
      WB2:     begin wb_next_state = WB3; wb_next_word = 2'd3; end
      default: ;
    endcase
  end

  logic        arr_we;
  logic [7:0]  arr_idx;
  logic [1:0]  arr_word;
  logic [15:0] arr_wdata;

  // On a write miss the requested word is merged from DataIn instead of memory.
  always_comb begin
    arr_we    = 1'b0;
    arr_idx   = req_idx;
    arr_word  = cap_word;
    arr_wdata = mem_data_in;
    if (accepting && accept && lookup_hit && cpu.Wr) begin
      arr_we    = 1'b1;
      arr_idx   = a_idx;
      arr_word  = a_off;
      arr_wdata = cpu.DataIn;
    end else if (state == FILL && capture) begin
      arr_we = 1'b1;
      if (req_wr && cap_word == req_off) arr_wdata = req_data;
    end
  end

  // NOTE: tag/data arrays are not reset; the valid bits gate every use of their contents.
  always_ff @(posedge clk) begin
    if (!rst && arr_we) data_arr[arr_idx][arr_word] <= arr_wdata;
    if (!rst && state == FILL && fill_last) tag_arr[req_idx] <= req_tag;
  end

  // NOTE: non-blocking assignments so every branch sees pre-edge state and array contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      done_q       <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      stall_q      <= 1'b0;
      data_out_q   <= '0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_addr     <= '0;
      mem_data_out <= '0;
      req_tag      <= '0;
      req_idx      <= '0;
      req_off      <= '0;
      req_wr       <= 1'b0;
      req_data     <= '0;
      fill_cyc     <= '0;
    end else begin
      done_q <= 1'b0;
      hit_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state   <= IDLE;
          stall_q <= 1'b0;
          mem_rd  <= 1'b0;
          mem_wr  <= 1'b0;
          if (illegal) begin
            err_q <= 1'b1;
          end else if (accept) begin
            req_tag  <= a_tag;
            req_idx  <= a_idx;
            req_off  <= a_off;
            req_wr   <= cpu.Wr;
            req_data <= cpu.DataIn;
            if (lookup_hit) begin
              state  <= DONE;
              done_q <= 1'b1;
              hit_q  <= 1'b1;
              if (cpu.Wr) dirty[a_idx] <= 1'b1;
              else        data_out_q   <= data_arr[a_idx][a_off];
            end else begin
              stall_q      <= 1'b1;
              valid[a_idx] <= 1'b0;
              if (valid[a_idx] && dirty[a_idx]) begin
                state        <= WB0;
                mem_wr       <= 1'b1;
                mem_addr     <= {tag_arr[a_idx], a_idx, 2'd0, 1'b0};
                mem_data_out <= data_arr[a_idx][0];
              end else begin
                state    <= FILL;
                fill_cyc <= '0;
                mem_rd   <= 1'b1;
                mem_addr <= {a_tag, a_idx, 2'd0, 1'b0};
              end
            end
          end
        end
        WB0, WB1, WB2: begin
          state        <= wb_next_state;
          mem_addr     <= {tag_arr[req_idx], req_idx, wb_next_word, 1'b0};
          mem_data_out <= data_arr[req_idx][wb_next_word];
        end
        WB3: begin
          state    <= FILL;
          fill_cyc <= '0;
          mem_wr   <= 1'b0;
          mem_rd   <= 1'b1;
          mem_addr <= {req_tag, req_idx, 2'd0, 1'b0};
        end
        FILL: begin
          fill_cyc <= fill_cyc + 3'd1;
          if (fill_cyc < 3'd3) begin
            mem_rd   <= 1'b1;
            mem_addr <= {req_tag, req_idx, issue_next, 1'b0};
          end else begin
            mem_rd <= 1'b0;
          end
          if (fill_last) begin
            valid[req_idx] <= 1'b1;
            dirty[req_idx] <= req_wr;
            state          <= DONE;
            done_q         <= 1'b1;
            stall_q        <= 1'b0;
            // The last captured word is still in flight, so take it straight from the port.
            if (!req_wr)
              data_out_q <= (req_off == cap_word) ? mem_data_in : data_arr[req_idx][req_off];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_system_dm.sv
// Directed bench for mem_system_dm: a fixed-latency backing memory, a scoreboard of expected
// responses and an ordered queue of expected memory transactions.
module tb_mem_system_dm;
  localparam int MEM_LAT = 2;
  localparam int BUDGET  = 40;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_system_dm_if cpu();
  logic [15:0] mem_addr, mem_data_out, mem_data_in;
  logic        mem_rd, mem_wr;

  mem_system_dm #(.MEM_LAT(MEM_LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .cpu          (cpu),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_data_out (mem_data_out),
    .mem_data_in  (mem_data_in)
  );

  typedef struct {
    logic        rd;
    logic        hit;
    logic [15:0] dout;
    int          lat;
  } exp_t;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
  } memop_t;

  exp_t   sb[$];
  memop_t mq[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  logic [15:0] wmem    [int];
  logic [15:0] ref_mem [int];
  int          rd_pipe [$];

  function automatic logic [15:0] base_val(input int w);
    if (w == 8) return 16'hBEEF;
    return 16'(w * 37) ^ 16'hA5C3;
  endfunction

  function automatic logic [15:0] back_read(input int w);
    return wmem.exists(w) ? wmem[w] : base_val(w);
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    int w = int'(a[15:1]);
    return ref_mem.exists(w) ? ref_mem[w] : base_val(w);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  // Backing memory: word returned MEM_LAT cycles after the cycle mem_rd was high.
  always @(posedge clk) begin
    int front;
    if (mem_wr) wmem[int'(mem_addr[15:1])] = mem_data_out;
    rd_pipe.push_back(mem_rd ? int'(mem_addr[15:1]) : -1);
    if (rd_pipe.size() > MEM_LAT) void'(rd_pipe.pop_front());
    front = rd_pipe[0];
    if (rd_pipe.size() == MEM_LAT && front >= 0) mem_data_in <= back_read(front);
    else                                         mem_data_in <= 16'hDEAD;
  end

  // Memory-port monitor: every transaction must match the next expected one in order.
  always @(negedge clk) begin
    memop_t m;
    if (mem_rd || mem_wr) begin
      check("mem_excl", 32'(mem_rd & mem_wr), 32'd0);
      if (mq.size() == 0) begin
        check("mem_unexpected", 32'({mem_rd, mem_wr}), 32'd0);
      end else begin
        m = mq.pop_front();
        check("mem_dir", 32'(mem_wr), 32'(m.wr));
        check("mem_addr", 32'(mem_addr), 32'(m.addr));
        if (m.wr) check("mem_wdata", 32'(mem_data_out), 32'(m.data));
      end
    end
  end

  task automatic expect_fill(input logic [15:0] base);
    for (int k = 0; k < 4; k++) begin
      memop_t m;
      m.wr = 1'b0; m.addr = base | 16'(k << 1); m.data = '0;
      mq.push_back(m);
    end
  endtask

  task automatic expect_wb(input logic [15:0] base);
    for (int k = 0; k < 4; k++) begin
      memop_t m;
      m.wr = 1'b1; m.addr = base | 16'(k << 1); m.data = ref_read(m.addr);
      mq.push_back(m);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_ctl"}, 32'({cpu.Done, cpu.CacheHit, cpu.Err, cpu.Stall, mem_rd, mem_wr}), 32'd0);
    check({tag, "_dout"}, 32'(cpu.DataOut), 32'd0);
    check({tag, "_maddr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mdata"}, 32'(mem_data_out), 32'd0);
  endtask

  // Drives one request at a negedge and waits (bounded) for Done; leaves Rd/Wr low at return.
  task automatic request(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [15:0] data, input logic exp_hit, input int exp_lat,
                         input string tag);
    exp_t e;
    int   cyc, stall_cycles;
    logic first_mem;
    e.rd = rd; e.hit = exp_hit; e.dout = ref_read(addr); e.lat = exp_lat;
    sb.push_back(e);
    if (wr) ref_mem[int'(addr[15:1])] = data;
    cpu.Rd = rd; cpu.Wr = wr; cpu.Addr = addr; cpu.DataIn = data;
    cyc = 0; stall_cycles = 0; first_mem = 1'b0;
    while (cyc < BUDGET) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 1) first_mem = mem_rd | mem_wr;
      if (cpu.Done) break;
      if (cpu.Stall) stall_cycles++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, 32'(cyc), 32'(e.lat));
    check({tag, "_hit"}, 32'(cpu.CacheHit), 32'(e.hit));
    if (e.rd) check({tag, "_data"}, 32'(cpu.DataOut), 32'(e.dout));
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(e.lat - 1));
    check({tag, "_stall_at_done"}, 32'(cpu.Stall), 32'd0);
    check({tag, "_mem_in_cycle1"}, 32'(first_mem), 32'(!e.hit));
    cpu.Rd = 1'b0; cpu.Wr = 1'b0;
  endtask

  task automatic illegal(input logic rd, input logic wr, input logic [15:0] addr,
                         input string tag);
    cpu.Rd = rd; cpu.Wr = wr; cpu.Addr = addr; cpu.DataIn = 16'h5555;
    @(posedge clk); @(negedge clk);
    check({tag, "_err"}, 32'(cpu.Err), 32'd1);
    check({tag, "_done_stall"}, 32'({cpu.Done, cpu.Stall}), 32'd0);
    cpu.Rd = 1'b0; cpu.Wr = 1'b0;
    @(posedge clk); @(negedge clk);
    check({tag, "_err_pulse"}, 32'({cpu.Err, cpu.Done, cpu.Stall}), 32'd0);
  endtask

  initial begin
    logic saw_done;
    rst = 1'b1;
    cpu.Rd = 1'b0; cpu.Wr = 1'b0; cpu.Addr = '0; cpu.DataIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;

    expect_fill(16'h0010);
    request(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 5 + MEM_LAT, "cold_rd");
    check("cold_rd_beef", 32'(cpu.DataOut), 32'h0000BEEF);
    request(1'b0, 1'b1, 16'h0012, 16'h1234, 1'b1, 1, "wr_hit");
    request(1'b1, 1'b0, 16'h0012, 16'h0000, 1'b1, 1, "rd_after_wr");

    expect_wb(16'h0010);
    expect_fill(16'h0810);
    request(1'b1, 1'b0, 16'h0810, 16'h0000, 1'b0, 9 + MEM_LAT, "dirty_rd");
    check("wb_mem_0012", 32'(back_read(int'(16'h0012 >> 1))), 32'h00001234);
    request(1'b1, 1'b0, 16'h0816, 16'h0000, 1'b1, 1, "rd_last_word");

    expect_fill(16'h2000);
    request(1'b0, 1'b1, 16'h2004, 16'h00AA, 1'b0, 5 + MEM_LAT, "wr_miss");
    request(1'b1, 1'b0, 16'h2004, 16'h0000, 1'b1, 1, "rd_wr_miss");
    expect_wb(16'h2000);
    expect_fill(16'h0000);
    request(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 9 + MEM_LAT, "evict_wr_miss");
    check("wb_mem_2004", 32'(back_read(int'(16'h2004 >> 1))), 32'h000000AA);

    illegal(1'b1, 1'b1, 16'h0100, "ill_rdwr");
    illegal(1'b1, 1'b0, 16'h0101, "ill_odd");

    // Reset during cycle 3 of a clean miss: three reads issued, then everything clears.
    for (int k = 0; k < 3; k++) begin
      memop_t m;
      m.wr = 1'b0; m.addr = 16'h0300 | 16'(k << 1); m.data = '0;
      mq.push_back(m);
    end
    cpu.Rd = 1'b1; cpu.Addr = 16'h0300;
    saw_done = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); @(negedge clk);
      saw_done |= cpu.Done;
    end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check_zero_outputs("mid_rst");
    check("mid_rst_no_done", 32'(saw_done), 32'd0);
    rst = 1'b0; cpu.Rd = 1'b0;
    @(posedge clk); @(negedge clk);
    expect_fill(16'h0300);
    request(1'b1, 1'b0, 16'h0300, 16'h0000, 1'b0, 5 + MEM_LAT, "reread_after_rst");

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mem_queue_drained", 32'(mq.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
